// File: rtl/pipe_ctrl_pkg.sv
// Shared field widths, forwarding encodings and stage control payloads for
// the pipeline control carrier.
package pipe_ctrl_pkg;

  localparam int unsigned ALU_OP_LENGTH  = 4;
  localparam int unsigned REG_SRC_LENGTH = 2;
  localparam int unsigned FWD_SEL_LENGTH = 2;

  // E-stage operand source select
  typedef enum logic [FWD_SEL_LENGTH-1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

  // Control fields carried into E (register indices kept separately)
  typedef struct packed {
    logic                      regfile_we;
    logic                      datamem_we;
    logic                      alusrc_mux;
    logic                      memtoreg;
    logic [ALU_OP_LENGTH-1:0]  aluop;
    logic [REG_SRC_LENGTH-1:0] regsrc_mux;
    logic                      branch;
  } e_ctrl_t;

  // Control fields still needed in M
  typedef struct packed {
    logic                      regfile_we;
    logic                      datamem_we;
    logic                      memtoreg;
    logic [REG_SRC_LENGTH-1:0] regsrc_mux;
  } m_ctrl_t;

  // Control fields still needed in W
  typedef struct packed {
    logic                      regfile_we;
    logic [REG_SRC_LENGTH-1:0] regsrc_mux;
  } w_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_unit.sv
// Combinational stall and forwarding equations.
// Ports:
//   rs_d, rt_d, branch_d          : D-stage sources and branch flag
//   rs_e, rt_e, write_reg_e, ...  : E-stage occupancy
//   write_reg_m, ... / _w         : M and W occupancy
//   stall                         : freeze F/D and bubble E
//   forward_a_e, forward_b_e      : E operand selects (M beats W)
//   forward_a_d, forward_b_d      : branch comparator operands from M
module hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0]     rs_d,
  input  logic [REG_ADDR_W-1:0]     rt_d,
  input  logic                      branch_d,
  input  logic [REG_ADDR_W-1:0]     rs_e,
  input  logic [REG_ADDR_W-1:0]     rt_e,
  input  logic [REG_ADDR_W-1:0]     write_reg_e,
  input  logic                      memtoreg_e,
  input  logic                      regfile_we_e,
  input  logic [REG_ADDR_W-1:0]     write_reg_m,
  input  logic                      memtoreg_m,
  input  logic                      regfile_we_m,
  input  logic [REG_ADDR_W-1:0]     write_reg_w,
  input  logic                      regfile_we_w,
  output logic                      stall,
  output logic [FWD_SEL_LENGTH-1:0] forward_a_e,
  output logic [FWD_SEL_LENGTH-1:0] forward_b_e,
  output logic                      forward_a_d,
  output logic                      forward_b_d
);

  // Register 0 is hardwired, so it never matches
  function automatic logic hit(input logic [REG_ADDR_W-1:0] dst,
                               input logic [REG_ADDR_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

  logic e_hits_d;
  logic m_hits_d;
  logic load_use;
  logic branch_e;
  logic branch_m;

  assign e_hits_d = hit(write_reg_e, rs_d) | hit(write_reg_e, rt_d);
  assign m_hits_d = hit(write_reg_m, rs_d) | hit(write_reg_m, rt_d);

  assign load_use = memtoreg_e & e_hits_d;
  assign branch_e = branch_d & regfile_we_e & e_hits_d;
  assign branch_m = branch_d & memtoreg_m & m_hits_d;

  // OR of all causes: coincident hazards still cost a single bubble
  assign stall = load_use | branch_e | branch_m;

  // W result is written through the regfile in time for D
  assign forward_a_d = regfile_we_m & hit(write_reg_m, rs_d);
  assign forward_b_d = regfile_we_m & hit(write_reg_m, rt_d);

  // E operand selects: the younger M result has priority over W
  always_comb begin
    forward_a_e = FWD_REG;
    forward_b_e = FWD_REG;
    if (regfile_we_m && hit(write_reg_m, rs_e)) begin
      forward_a_e = FWD_M;
    end else if (regfile_we_w && hit(write_reg_w, rs_e)) begin
      forward_a_e = FWD_W;
    end
    if (regfile_we_m && hit(write_reg_m, rt_e)) begin
      forward_b_e = FWD_M;
    end else if (regfile_we_w && hit(write_reg_w, rt_e)) begin
      forward_b_e = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Carries the decoded control bundle through the E, M and W stage registers
// and exposes hazard/forwarding controls for the datapath.
// Ports:
//   clk, rst                : core clock, synchronous active-high reset
//   *D                      : decoded D-stage bundle and source indices
//   *E, *M, *W              : registered per-stage copies of the bundle
//   stallF, stallD, flushE  : combinational hazard response
//   forwardAE/BE, AD/BD     : combinational operand forwarding selects
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Regfile_weD,
  input  logic                      DataMem_weD,
  input  logic                      aluSrc_muxD,
  input  logic                      memToRegD,
  input  logic [ALU_OP_LENGTH-1:0]  aluOpD,
  input  logic [REG_SRC_LENGTH-1:0] regSrc_muxD,
  input  logic                      branchD,
  input  logic [REG_ADDR_W-1:0]     rsD,
  input  logic [REG_ADDR_W-1:0]     rtD,
  input  logic [REG_ADDR_W-1:0]     writeRegD,
  output logic                      Regfile_weE,
  output logic                      DataMem_weE,
  output logic                      aluSrc_muxE,
  output logic                      memToRegE,
  output logic [ALU_OP_LENGTH-1:0]  aluOpE,
  output logic [REG_SRC_LENGTH-1:0] regSrc_muxE,
  output logic                      branchE,
  output logic [REG_ADDR_W-1:0]     rsE,
  output logic [REG_ADDR_W-1:0]     rtE,
  output logic [REG_ADDR_W-1:0]     writeRegE,
  output logic                      Regfile_weM,
  output logic                      DataMem_weM,
  output logic                      memToRegM,
  output logic [REG_SRC_LENGTH-1:0] regSrc_muxM,
  output logic [REG_ADDR_W-1:0]     writeRegM,
  output logic                      Regfile_weW,
  output logic [REG_SRC_LENGTH-1:0] regSrc_muxW,
  output logic [REG_ADDR_W-1:0]     writeRegW,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      flushE,
  output logic [FWD_SEL_LENGTH-1:0] forwardAE,
  output logic [FWD_SEL_LENGTH-1:0] forwardBE,
  output logic                      forwardAD,
  output logic                      forwardBD
);

  e_ctrl_t                ctrl_d;
  e_ctrl_t                ctrl_e;
  m_ctrl_t                ctrl_m;
  w_ctrl_t                ctrl_w;
  logic [REG_ADDR_W-1:0]  rs_e;
  logic [REG_ADDR_W-1:0]  rt_e;
  logic [REG_ADDR_W-1:0]  wr_e;
  logic [REG_ADDR_W-1:0]  wr_m;
  logic [REG_ADDR_W-1:0]  wr_w;
  logic                   stall;

  assign ctrl_d = '{regfile_we: Regfile_weD, datamem_we: DataMem_weD,
                    alusrc_mux: aluSrc_muxD, memtoreg: memToRegD,
                    aluop: aluOpD, regsrc_mux: regSrc_muxD,
                    branch: branchD};

  // Stage registers; a stall inserts an all-zero bubble (ALU NOP) into E
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_e <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
      wr_e   <= '0;
      ctrl_m <= '0;
      wr_m   <= '0;
      ctrl_w <= '0;
      wr_w   <= '0;
    end else begin
      if (stall) begin
        ctrl_e <= '0;
        rs_e   <= '0;
        rt_e   <= '0;
        wr_e   <= '0;
      end else begin
        ctrl_e <= ctrl_d;
        rs_e   <= rsD;
        rt_e   <= rtD;
        wr_e   <= writeRegD;
      end
      ctrl_m <= '{regfile_we: ctrl_e.regfile_we, datamem_we: ctrl_e.datamem_we,
                  memtoreg: ctrl_e.memtoreg, regsrc_mux: ctrl_e.regsrc_mux};
      wr_m   <= wr_e;
      ctrl_w <= '{regfile_we: ctrl_m.regfile_we, regsrc_mux: ctrl_m.regsrc_mux};
      wr_w   <= wr_m;
    end
  end

  assign Regfile_weE = ctrl_e.regfile_we;
  assign DataMem_weE = ctrl_e.datamem_we;
  assign aluSrc_muxE = ctrl_e.alusrc_mux;
  assign memToRegE   = ctrl_e.memtoreg;
  assign aluOpE      = ctrl_e.aluop;
  assign regSrc_muxE = ctrl_e.regsrc_mux;
  assign branchE     = ctrl_e.branch;
  assign rsE         = rs_e;
  assign rtE         = rt_e;
  assign writeRegE   = wr_e;
  assign Regfile_weM = ctrl_m.regfile_we;
  assign DataMem_weM = ctrl_m.datamem_we;
  assign memToRegM   = ctrl_m.memtoreg;
  assign regSrc_muxM = ctrl_m.regsrc_mux;
  assign writeRegM   = wr_m;
  assign Regfile_weW = ctrl_w.regfile_we;
  assign regSrc_muxW = ctrl_w.regsrc_mux;
  assign writeRegW   = wr_w;

  assign stallF = stall;
  assign stallD = stall;
  assign flushE = stall;

  hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .rs_d         (rsD),
    .rt_d         (rtD),
    .branch_d     (branchD),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .write_reg_e  (wr_e),
    .memtoreg_e   (ctrl_e.memtoreg),
    .regfile_we_e (ctrl_e.regfile_we),
    .write_reg_m  (wr_m),
    .memtoreg_m   (ctrl_m.memtoreg),
    .regfile_we_m (ctrl_m.regfile_we),
    .write_reg_w  (wr_w),
    .regfile_we_w (ctrl_w.regfile_we),
    .stall        (stall),
    .forward_a_e  (forwardAE),
    .forward_b_e  (forwardBE),
    .forward_a_d  (forwardAD),
    .forward_b_d  (forwardBD)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver advances a queue-style pipeline
// model each cycle and pushes the expected outputs; a negedge monitor pops
// and compares against the DUT.
module tb_pipe_ctrl;

  typedef struct packed {
    logic       rwe;
    logic       dwe;
    logic       asrc;
    logic       m2r;
    logic [3:0] aop;
    logic [1:0] rsrc;
    logic       br;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wr;
  } txn_t;

  typedef struct packed {
    logic [25:0] e;
    logic [17:0] mw;
    logic [8:0]  hz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  txn_t d_drv = '0;

  logic       Regfile_weE, DataMem_weE, aluSrc_muxE, memToRegE, branchE;
  logic [3:0] aluOpE;
  logic [1:0] regSrc_muxE, regSrc_muxM, regSrc_muxW;
  logic [4:0] rsE, rtE, writeRegE, writeRegM, writeRegW;
  logic       Regfile_weM, DataMem_weM, memToRegM, Regfile_weW;
  logic       stallF, stallD, flushE, forwardAD, forwardBD;
  logic [1:0] forwardAE, forwardBE;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .Regfile_weD(d_drv.rwe), .DataMem_weD(d_drv.dwe),
    .aluSrc_muxD(d_drv.asrc), .memToRegD(d_drv.m2r),
    .aluOpD(d_drv.aop), .regSrc_muxD(d_drv.rsrc), .branchD(d_drv.br),
    .rsD(d_drv.rs), .rtD(d_drv.rt), .writeRegD(d_drv.wr),
    .Regfile_weE(Regfile_weE), .DataMem_weE(DataMem_weE),
    .aluSrc_muxE(aluSrc_muxE), .memToRegE(memToRegE), .aluOpE(aluOpE),
    .regSrc_muxE(regSrc_muxE), .branchE(branchE), .rsE(rsE), .rtE(rtE),
    .writeRegE(writeRegE),
    .Regfile_weM(Regfile_weM), .DataMem_weM(DataMem_weM),
    .memToRegM(memToRegM), .regSrc_muxM(regSrc_muxM), .writeRegM(writeRegM),
    .Regfile_weW(Regfile_weW), .regSrc_muxW(regSrc_muxW), .writeRegW(writeRegW),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD)
  );

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  // Reference pipeline: slot 0 = E, 1 = M, 2 = W
  txn_t pipe[3];
  txn_t d_q       = '0;
  logic rst_q     = 1'b1;
  logic cur_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fsel(input logic [4:0] src);
    if (pipe[1].rwe && hit(pipe[1].wr, src)) return 2'b10;
    if (pipe[2].rwe && hit(pipe[2].wr, src)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic model_stall(input txn_t d);
    logic e_dep, m_dep;
    e_dep = hit(pipe[0].wr, d.rs) || hit(pipe[0].wr, d.rt);
    m_dep = hit(pipe[1].wr, d.rs) || hit(pipe[1].wr, d.rt);
    return (pipe[0].m2r && e_dep) || (d.br && pipe[0].rwe && e_dep) ||
           (d.br && pipe[1].m2r && m_dep);
  endfunction

  function automatic logic [25:0] pack_e(input txn_t t);
    return {t.rwe, t.dwe, t.asrc, t.m2r, t.aop, t.rsrc, t.br, t.rs, t.rt, t.wr};
  endfunction

  function automatic logic [17:0] pack_mw(input txn_t m, input txn_t w);
    return {m.rwe, m.dwe, m.m2r, m.rsrc, m.wr, w.rwe, w.rsrc, w.wr};
  endfunction

  // Advance one clock: retire the model edge, drive new D, push expectation
  task automatic step(input logic r, input txn_t d);
    exp_t x;
    @(posedge clk);
    #1;
    if (rst_q) begin
      for (int i = 0; i < 3; i++) pipe[i] = '0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = cur_stall ? txn_t'(0) : d_q;
    end
    rst   = r;
    d_drv = d;
    rst_q = r;
    d_q   = d;
    cur_stall = model_stall(d);
    x.e  = pack_e(pipe[0]);
    x.mw = pack_mw(pipe[1], pipe[2]);
    x.hz = {cur_stall, cur_stall, cur_stall, fsel(pipe[0].rs), fsel(pipe[0].rt),
            pipe[1].rwe && hit(pipe[1].wr, d.rs),
            pipe[1].rwe && hit(pipe[1].wr, d.rt)};
    sb.push_back(x);
  endtask

  // Hold an instruction in D until the DUT stops stalling it
  task automatic issue(input txn_t t, output int stalls, output logic [1:0] fae,
                       output logic [1:0] fbe, output logic fad, output logic fbd);
    stalls = 0;
    fae = 2'b00; fbe = 2'b00; fad = 1'b0; fbd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, t);
      #1;
      fae = forwardAE; fbe = forwardBE; fad = forwardAD; fbd = forwardBD;
      if (!stallF) break;
      stalls++;
    end
  endtask

  function automatic txn_t mk_alu(input logic [3:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs, input logic [4:0] rt);
    txn_t t = '0;
    t.rwe = 1'b1; t.aop = op; t.rs = rs; t.rt = rt; t.wr = rd;
    return t;
  endfunction

  function automatic txn_t mk_lw(input logic [4:0] rt, input logic [4:0] base);
    txn_t t = '0;
    t.rwe = 1'b1; t.asrc = 1'b1; t.m2r = 1'b1; t.aop = 4'd2; t.rsrc = 2'd1;
    t.rs = base; t.rt = rt; t.wr = rt;
    return t;
  endfunction

  function automatic txn_t mk_beq(input logic [4:0] rs, input logic [4:0] rt);
    txn_t t = '0;
    t.br = 1'b1; t.aop = 4'd6; t.rs = rs; t.rt = rt;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.rwe  = 1'($urandom);
    t.dwe  = 1'($urandom);
    t.asrc = 1'($urandom);
    t.m2r  = 1'($urandom);
    t.aop  = 4'($urandom);
    t.rsrc = 2'($urandom);
    t.br   = 1'($urandom);
    t.rs   = 5'($urandom_range(0, 3));
    t.rt   = 5'($urandom_range(0, 3));
    t.wr   = 5'($urandom_range(0, 3));
    return t;
  endfunction

  // Monitor: compare every cycle's DUT outputs against the oldest expectation
  initial begin
    exp_t x;
    logic [25:0] ae;
    logic [17:0] amw;
    logic [8:0]  ahz;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x   = sb.pop_front();
        ae  = {Regfile_weE, DataMem_weE, aluSrc_muxE, memToRegE, aluOpE,
               regSrc_muxE, branchE, rsE, rtE, writeRegE};
        amw = {Regfile_weM, DataMem_weM, memToRegM, regSrc_muxM, writeRegM,
               Regfile_weW, regSrc_muxW, writeRegW};
        ahz = {stallF, stallD, flushE, forwardAE, forwardBE, forwardAD, forwardBD};
        chk("stage_e", 32'(ae), 32'(x.e));
        chk("stage_mw", 32'(amw), 32'(x.mw));
        chk("hazard", 32'(ahz), 32'(x.hz));
      end
    end
  end

  initial begin
    txn_t nop = '0;
    txn_t busy;
    int s;
    logic [1:0] fae, fbe;
    logic fad, fbd;

    for (int i = 0; i < 3; i++) pipe[i] = '0;

    // Reset with a live D bundle, then release and watch E capture it
    busy = mk_lw(5'd8, 5'd8);
    busy.dwe = 1'b1; busy.br = 1'b1;
    step(1'b1, busy);
    step(1'b1, busy);
    #1;
    chk("rst_e_zero", 32'(pack_e({Regfile_weE, DataMem_weE, aluSrc_muxE, memToRegE,
        aluOpE, regSrc_muxE, branchE, rsE, rtE, writeRegE})), 32'd0);
    chk("rst_w_zero", 32'({Regfile_weW, regSrc_muxW, writeRegW}), 32'd0);
    chk("rst_hz_zero", 32'({stallF, forwardAE, forwardBE, forwardAD, forwardBD}), 32'd0);
    step(1'b0, busy);
    step(1'b0, nop);
    #1;
    chk("rst_capture", 32'({Regfile_weE, DataMem_weE, aluSrc_muxE, memToRegE, aluOpE,
        regSrc_muxE, branchE, rsE, rtE, writeRegE}), 32'(pack_e(busy)));
    repeat (3) issue(nop, s, fae, fbe, fad, fbd);

    // Load-use: one stall, then W forwards to E
    issue(mk_lw(5'd8, 5'd29), s, fae, fbe, fad, fbd);
    issue(mk_alu(4'd2, 5'd9, 5'd8, 5'd10), s, fae, fbe, fad, fbd);
    chk("lu_stalls", 32'(s), 32'd1);
    issue(nop, s, fae, fbe, fad, fbd);
    chk("lu_fwd_a", 32'(fae), 32'd1);
    chk("lu_fwd_b", 32'(fbe), 32'd0);
    repeat (3) issue(nop, s, fae, fbe, fad, fbd);

    // M beats W on both operands
    issue(mk_alu(4'd2, 5'd8, 5'd1, 5'd2), s, fae, fbe, fad, fbd);
    issue(mk_alu(4'd6, 5'd8, 5'd3, 5'd4), s, fae, fbe, fad, fbd);
    issue(mk_alu(4'd1, 5'd11, 5'd8, 5'd8), s, fae, fbe, fad, fbd);
    chk("prio_stalls", 32'(s), 32'd0);
    issue(nop, s, fae, fbe, fad, fbd);
    chk("prio_fwd_a", 32'(fae), 32'd2);
    chk("prio_fwd_b", 32'(fbe), 32'd2);
    repeat (3) issue(nop, s, fae, fbe, fad, fbd);

    // Branch after ALU producer
    issue(mk_alu(4'd2, 5'd8, 5'd1, 5'd2), s, fae, fbe, fad, fbd);
    issue(mk_beq(5'd8, 5'd9), s, fae, fbe, fad, fbd);
    chk("br_alu_stalls", 32'(s), 32'd1);
    chk("br_alu_fwd_ad", 32'(fad), 32'd1);
    chk("br_alu_fwd_bd", 32'(fbd), 32'd0);
    repeat (3) issue(nop, s, fae, fbe, fad, fbd);

    // Branch after load: two stalls, then regfile write-through
    issue(mk_lw(5'd8, 5'd29), s, fae, fbe, fad, fbd);
    issue(mk_beq(5'd8, 5'd8), s, fae, fbe, fad, fbd);
    chk("br_lw_stalls", 32'(s), 32'd2);
    chk("br_lw_fwd_d", 32'({fad, fbd}), 32'd0);
    repeat (3) issue(nop, s, fae, fbe, fad, fbd);

    // Register 0 is never a dependency
    issue(mk_lw(5'd0, 5'd29), s, fae, fbe, fad, fbd);
    issue(mk_alu(4'd2, 5'd9, 5'd0, 5'd0), s, fae, fbe, fad, fbd);
    chk("r0_stalls", 32'(s), 32'd0);
    issue(nop, s, fae, fbe, fad, fbd);
    chk("r0_fwd_e", 32'({fae, fbe}), 32'd0);

    // Random traffic with occasional mid-stream reset
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, rand_txn());
    end

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
